life_engine: RTL and testbench

//  Parametrised Conway Game-of-Life engine: holds a ROWS x COLS cell grid, loads a seed, advances

---
 rtl/life_engine.sv | 144 ++++++++++++++
 tb/tb_life_engine.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/life_engine.sv
// life_engine: Conway Game-of-Life engine over a ROWS x COLS grid.
// Loads a seed, then advances generations either on a single step or by
// free-running at one generation per TICK_DIV clocks. It halts itself once
// a generation leaves the grid unchanged.
// Optional feature macro: LIFE_WRAP_EN (toroidal neighbour lookup).
// When it is undefined, cells outside the grid count as dead.

module life_engine #(
    parameter int unsigned ROWS     = 8,
    parameter int unsigned COLS     = 8,
    parameter int unsigned GEN_W    = 16,
    parameter int unsigned TICK_DIV = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [ROWS*COLS-1:0] seed,
    input  logic                 step,
    input  logic                 run,
    output logic [ROWS*COLS-1:0] grid_o,
    output logic [GEN_W-1:0]     gen_o,
    output logic [1:0]           state_o,
    output logic                 extinct_o
);

    localparam int unsigned N      = ROWS * COLS;
    localparam int unsigned IDX_W  = $clog2(N);
    localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        PAUSE = 2'd1,
        RUN   = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t            state;
    logic [TICK_W-1:0] tick;
    logic [N-1:0]      nxt;
    logic              changed;

    // Contribution of one neighbour: 1 if it is in range and alive.
    function automatic logic [3:0] live(input logic [N-1:0] g, input logic ok,
                                        input int unsigned rr, input int unsigned cc);
        return ok ? {3'b000, g[IDX_W'(rr * COLS + cc)]} : 4'd0;
    endfunction

    // Next generation: count the live neighbours of each cell and apply the B3/S23 rule.
    always_comb begin
        int unsigned rn, rs, cw, ce;
        logic        vn, vs, vw, ve;
        logic [3:0]  cnt;
        nxt = '0;
        for (int unsigned r = 0; r < ROWS; r++) begin
            for (int unsigned c = 0; c < COLS; c++) begin
                // The neighbour indices always wrap, so every lookup stays in range.
                // Without wrap, the valid flags mask off the out-of-grid neighbours.
                rn = (r == 0)        ? ROWS - 1 : r - 1;
                rs = (r == ROWS - 1) ? 0        : r + 1;
                cw = (c == 0)        ? COLS - 1 : c - 1;
                ce = (c == COLS - 1) ? 0        : c + 1;
`ifdef LIFE_WRAP_EN
                vn = 1'b1;
                vs = 1'b1;
                vw = 1'b1;
                ve = 1'b1;
`else
                vn = (r != 0);
                vs = (r != ROWS - 1);
                vw = (c != 0);
                ve = (c != COLS - 1);
`endif
                cnt = live(grid_o, vn & vw, rn, cw) + live(grid_o, vn, rn, c)
                    + live(grid_o, vn & ve, rn, ce) + live(grid_o, vw, r, cw)
                    + live(grid_o, ve, r, ce)       + live(grid_o, vs & vw, rs, cw)
                    + live(grid_o, vs, rs, c)       + live(grid_o, vs & ve, rs, ce);
                nxt[IDX_W'(r * COLS + c)] = (cnt == 4'd3) |
                                            (grid_o[IDX_W'(r * COLS + c)] & (cnt == 4'd2));
            end
        end
    end

    // Flag whether an update would alter the grid; a stable grid means halt.
    always_comb begin
        changed = (nxt != grid_o);
    end

    // Control FSM with grid, generation and tick registers. Priority is reset > load > step/run.
    always_ff @(posedge clk) begin
        if (reset) begin
            grid_o <= '0;
            gen_o  <= '0;
            tick   <= '0;
            state  <= EMPTY;
        end else if (load) begin
            grid_o <= seed;
            gen_o  <= '0;
            tick   <= '0;
            state  <= PAUSE;
        end else begin
            case (state)
                PAUSE: begin
                    if (step) begin
                        if (changed) begin
                            grid_o <= nxt;
                            gen_o  <= gen_o + GEN_W'(1);
                        end else begin
                            state <= HALT;
                        end
                    end else if (run) begin
                        state <= RUN;
                        tick  <= '0;
                    end
                end
                RUN: begin
                    if (!run) begin
                        state <= PAUSE;
                        tick  <= '0;
                    end else if (tick == TICK_W'(TICK_DIV - 1)) begin
                        tick <= '0;
                        if (changed) begin
                            grid_o <= nxt;
                            gen_o  <= gen_o + GEN_W'(1);
                        end else begin
                            state <= HALT;
                        end
                    end else begin
                        tick <= tick + TICK_W'(1);
                    end
                end
                default: begin
                    // EMPTY and HALT ignore step and run; only load or reset leaves them.
                end
            endcase
        end
    end

    // Drive the status outputs straight from the grid and state registers.
    always_comb begin
        state_o   = state;
        extinct_o = (grid_o == '0);
    end

endmodule

// File: tb/tb_life_engine.sv
// tb_life_engine: directed self-checking bench for life_engine.
// The bench uses two instances: the default 8x8 engine with TICK_DIV=1, and a TICK_DIV=4 engine for the rate test.
// It honours LIFE_WRAP_EN for the expected edge-behaviour results.

module tb_life_engine;

    localparam logic [63:0] BLINK_H = 64'h0000_0000_1C00_0000;
    localparam logic [63:0] BLINK_V = 64'h0000_0008_0808_0000;
    localparam logic [63:0] BLOCK   = 64'h0000_0000_0000_0303;
    localparam logic [63:0] EDGE_S  = 64'h0000_0000_0000_0083;
    localparam logic [63:0] EDGE_W  = 64'h0100_0000_0000_0101;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        load = 1'b0, step = 1'b0, run = 1'b0;
    logic [63:0] seed = '0;
    logic [63:0] grid_o;
    logic [15:0] gen_o;
    logic [1:0]  state_o;
    logic        extinct_o;

    logic        load4 = 1'b0, step4 = 1'b0, run4 = 1'b0;
    logic [63:0] seed4 = '0;
    logic [63:0] grid4;
    logic [15:0] gen4;
    logic [1:0]  state4;
    logic        extinct4;

    int checks = 0;
    int failures = 0;

    life_engine dut (
        .clk(clk), .reset(reset), .load(load), .seed(seed), .step(step), .run(run),
        .grid_o(grid_o), .gen_o(gen_o), .state_o(state_o), .extinct_o(extinct_o)
    );

    life_engine #(.TICK_DIV(4)) dut4 (
        .clk(clk), .reset(reset), .load(load4), .seed(seed4), .step(step4), .run(run4),
        .grid_o(grid4), .gen_o(gen4), .state_o(state4), .extinct_o(extinct4)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        checks++; if (grid_o !== 64'd0) begin failures++; $display("FAIL reset_grid got=%h exp=0", grid_o); end
        checks++; if (gen_o !== 16'd0) begin failures++; $display("FAIL reset_gen got=%0d exp=0", gen_o); end
        checks++; if (state_o !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state_o); end
        checks++; if (extinct_o !== 1'b1) begin failures++; $display("FAIL reset_extinct got=%b exp=1", extinct_o); end
        checks++; if (state4 !== 2'd0) begin failures++; $display("FAIL reset_state4 got=%0d exp=0", state4); end
        step = 1'b1; cyc(); step = 1'b0;
        run = 1'b1; cyc(); cyc(); run = 1'b0;
        checks++; if (state_o !== 2'd0 || grid_o !== 64'd0) begin failures++; $display("FAIL empty_ignore state=%0d grid=%h exp state=0 grid=0", state_o, grid_o); end
    endtask

    task automatic test_blinker();
        seed = BLINK_H; load = 1'b1; cyc(); load = 1'b0;
        checks++; if (grid_o !== BLINK_H || gen_o !== 16'd0 || state_o !== 2'd1) begin failures++; $display("FAIL blink_load grid=%h gen=%0d state=%0d exp %h 0 1", grid_o, gen_o, state_o, BLINK_H); end
        checks++; if (extinct_o !== 1'b0) begin failures++; $display("FAIL blink_extinct got=%b exp=0", extinct_o); end
        step = 1'b1; cyc(); step = 1'b0;
        checks++; if (grid_o !== BLINK_V || gen_o !== 16'd1) begin failures++; $display("FAIL blink_step1 grid=%h gen=%0d exp %h 1", grid_o, gen_o, BLINK_V); end
        step = 1'b1; cyc(); step = 1'b0;
        checks++; if (grid_o !== BLINK_H || gen_o !== 16'd2 || state_o !== 2'd1) begin failures++; $display("FAIL blink_step2 grid=%h gen=%0d state=%0d exp %h 2 1", grid_o, gen_o, state_o, BLINK_H); end
    endtask

    task automatic test_still_life();
        seed = BLOCK; load = 1'b1; cyc(); load = 1'b0;
        step = 1'b1; cyc(); step = 1'b0;
        checks++; if (grid_o !== BLOCK || gen_o !== 16'd0 || state_o !== 2'd3) begin failures++; $display("FAIL still_halt grid=%h gen=%0d state=%0d exp %h 0 3", grid_o, gen_o, state_o, BLOCK); end
        step = 1'b1; cyc(); step = 1'b0;
        run = 1'b1; cyc(); cyc(); run = 1'b0;
        checks++; if (grid_o !== BLOCK || gen_o !== 16'd0 || state_o !== 2'd3) begin failures++; $display("FAIL still_frozen grid=%h gen=%0d state=%0d exp %h 0 3", grid_o, gen_o, state_o, BLOCK); end
    endtask

    task automatic test_edges();
        seed = EDGE_S; load = 1'b1; cyc(); load = 1'b0;
        step = 1'b1; cyc(); step = 1'b0;
`ifdef LIFE_WRAP_EN
        checks++; if (grid_o !== EDGE_W || gen_o !== 16'd1 || extinct_o !== 1'b0) begin failures++; $display("FAIL edge_wrap grid=%h gen=%0d ext=%b exp %h 1 0", grid_o, gen_o, extinct_o, EDGE_W); end
`else
        checks++; if (grid_o !== 64'd0 || gen_o !== 16'd1 || extinct_o !== 1'b1 || state_o !== 2'd1) begin failures++; $display("FAIL edge_hard grid=%h gen=%0d ext=%b state=%0d exp 0 1 1 1", grid_o, gen_o, extinct_o, state_o); end
        step = 1'b1; cyc(); step = 1'b0;
        checks++; if (state_o !== 2'd3 || gen_o !== 16'd1) begin failures++; $display("FAIL edge_extinct_halt state=%0d gen=%0d exp 3 1", state_o, gen_o); end
`endif
    endtask

    task automatic test_rate();
        logic [15:0] eg;
        seed4 = BLINK_H; load4 = 1'b1; cyc(); load4 = 1'b0;
        run4 = 1'b1; cyc();
        checks++; if (state4 !== 2'd2 || gen4 !== 16'd0) begin failures++; $display("FAIL rate_entry state=%0d gen=%0d exp 2 0", state4, gen4); end
        for (int i = 1; i <= 12; i++) begin
            cyc();
            eg = 16'(i / 4);
            checks++; if (gen4 !== eg || grid4 !== (eg[0] ? BLINK_V : BLINK_H)) begin failures++; $display("FAIL rate_cycle%0d gen=%0d grid=%h exp gen=%0d", i, gen4, grid4, eg); end
        end
        run4 = 1'b0; cyc();
        checks++; if (state4 !== 2'd1 || gen4 !== 16'd3) begin failures++; $display("FAIL rate_stop state=%0d gen=%0d exp 1 3", state4, gen4); end
        cyc();
        checks++; if (gen4 !== 16'd3) begin failures++; $display("FAIL rate_hold gen=%0d exp 3", gen4); end
    endtask

    task automatic test_priority();
        seed = BLINK_H; load = 1'b1; cyc(); load = 1'b0;
        step = 1'b1; run = 1'b1; cyc(); step = 1'b0; run = 1'b0;
        checks++; if (state_o !== 2'd1 || gen_o !== 16'd1 || grid_o !== BLINK_V) begin failures++; $display("FAIL step_run_pause state=%0d gen=%0d grid=%h exp 1 1 %h", state_o, gen_o, grid_o, BLINK_V); end
        load = 1'b1; step = 1'b1; cyc(); load = 1'b0; step = 1'b0;
        checks++; if (grid_o !== BLINK_H || gen_o !== 16'd0 || state_o !== 2'd1) begin failures++; $display("FAIL load_step grid=%h gen=%0d state=%0d exp %h 0 1", grid_o, gen_o, state_o, BLINK_H); end
        run = 1'b1; cyc();
        checks++; if (state_o !== 2'd2 || gen_o !== 16'd0) begin failures++; $display("FAIL run_entry state=%0d gen=%0d exp 2 0", state_o, gen_o); end
        cyc(); cyc();
        checks++; if (gen_o !== 16'd2 || grid_o !== BLINK_H) begin failures++; $display("FAIL run_div1 gen=%0d grid=%h exp 2 %h", gen_o, grid_o, BLINK_H); end
        load = 1'b1; cyc(); load = 1'b0; run = 1'b0;
        checks++; if (state_o !== 2'd1 || gen_o !== 16'd0 || grid_o !== BLINK_H) begin failures++; $display("FAIL load_in_run state=%0d gen=%0d grid=%h exp 1 0 %h", state_o, gen_o, grid_o, BLINK_H); end
    endtask

    task automatic test_reset_mid_run();
        seed = BLINK_H; load = 1'b1; cyc(); load = 1'b0;
        run = 1'b1; cyc();
        for (int i = 0; i < 5; i++) cyc();
        checks++; if (gen_o !== 16'd5 || state_o !== 2'd2 || grid_o !== BLINK_V) begin failures++; $display("FAIL run_gen5 gen=%0d state=%0d grid=%h exp 5 2 %h", gen_o, state_o, grid_o, BLINK_V); end
        reset = 1'b1; cyc(); reset = 1'b0;
        checks++; if (grid_o !== 64'd0 || gen_o !== 16'd0 || state_o !== 2'd0 || extinct_o !== 1'b1) begin failures++; $display("FAIL reset_mid_run grid=%h gen=%0d state=%0d ext=%b exp 0 0 0 1", grid_o, gen_o, state_o, extinct_o); end
        cyc();
        step = 1'b1; cyc(); step = 1'b0; run = 1'b0;
        checks++; if (grid_o !== 64'd0 || gen_o !== 16'd0 || state_o !== 2'd0) begin failures++; $display("FAIL post_reset_ignore grid=%h gen=%0d state=%0d exp 0 0 0", grid_o, gen_o, state_o); end
    endtask

    initial begin
        test_reset();
        test_blinker();
        test_still_life();
        test_edges();
        test_rate();
        test_priority();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
